// File: rtl/stage_mem.sv
// Memory-access pipeline stage: turns load/store micro-ops into single data-bus cycles,
// checks alignment, formats load data for write-back and stalls until the bus terminates.
module stage_mem (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        is_ld_mem_i,
  input  logic        is_st_mem_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] st_data_i,
  input  logic        flush_i,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i,
  output logic [31:0] mem_d_o,
  output logic        stall_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_bus_err_o
);

  typedef enum logic {StIdle, StBus} state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;

  logic        req;
  logic        legal;
  logic        misaligned;
  logic        start;
  logic        done;
  logic [1:0]  off;
  logic [3:0]  st_sel;
  logic [31:0] st_dat;
  logic [31:0] lane;
  logic [31:0] ld_fmt;

  assign req = valid_i & (is_ld_mem_i | is_st_mem_i);
  assign off = alu_d_i[1:0];

  // Unsigned sizes exist only for loads; anything else is a silent no-op here.
  always_comb begin
    legal = 1'b0;
    unique case (funct3_i)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~is_st_mem_i;
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    unique case (funct3_i[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  end

  assign e_ld_addr_mis_o = req & legal & misaligned & ~is_st_mem_i;
  assign e_st_addr_mis_o = req & legal & misaligned & is_st_mem_i;

  assign start = req & legal & ~misaligned & ~flush_i & (state_q == StIdle);
  assign done  = (state_q == StBus) & (dwbm_ack_i | dwbm_err_i);

  always_comb begin
    st_sel = 4'b1111;
    st_dat = st_data_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        st_sel = 4'b0001 << off;
        st_dat = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_sel = off[1] ? 4'b1100 : 4'b0011;
        st_dat = {2{st_data_i[15:0]}};
      end
      default: begin
        st_sel = 4'b1111;
        st_dat = st_data_i;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    off_d    = off_q;
    funct3_d = funct3_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StBus;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          we_d     = is_st_mem_i;
          addr_d   = {alu_d_i[31:2], 2'b00};
          dat_d    = is_st_mem_i ? st_dat : 32'h0;
          sel_d    = is_st_mem_i ? st_sel : 4'b1111;
          off_d    = off;
          funct3_d = funct3_i;
        end
      end
      StBus: begin
        // An access in flight is never aborted; only ack/err ends it.
        if (done) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      dat_q    <= 32'h0;
      sel_q    <= 4'b0000;
      off_q    <= 2'b00;
      funct3_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      off_q    <= off_d;
      funct3_q <= funct3_d;
    end
  end

  assign lane = dwbm_dat_i >> {off_q, 3'b000};

  always_comb begin
    ld_fmt = lane;
    unique case (funct3_q)
      3'b000:  ld_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_fmt = {24'h0, lane[7:0]};
      3'b101:  ld_fmt = {16'h0, lane[15:0]};
      default: ld_fmt = lane;
    endcase
  end

  // Error wins over a simultaneous ack, so load data is only presented on a clean ack.
  assign mem_d_o = ((state_q == StBus) & dwbm_ack_i & ~dwbm_err_i & ~we_q) ? ld_fmt : 32'h0;

  assign stall_o     = ((state_q == StIdle) & start) |
                       ((state_q == StBus) & ~(dwbm_ack_i | dwbm_err_i));
  assign e_bus_err_o = (state_q == StBus) & dwbm_err_i;

  assign dwbm_addr_o = addr_q;
  assign dwbm_dat_o  = dat_q;
  assign dwbm_sel_o  = sel_q;
  assign dwbm_we_o   = we_q;
  assign dwbm_cyc_o  = cyc_q;
  assign dwbm_stb_o  = stb_q;

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: hand-written vector table, randomized accesses against an
// arithmetic reference model, and an asynchronous-reset-during-access sequence.
module tb_stage_mem;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, is_ld_mem_i, is_st_mem_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_d_i, st_data_i;
  logic [31:0] dwbm_addr_o, dwbm_dat_o, dwbm_dat_i, mem_d_o;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_we_o, dwbm_cyc_o, dwbm_stb_o, dwbm_ack_i, dwbm_err_i;
  logic        stall_o, e_ld_addr_mis_o, e_st_addr_mis_o, e_bus_err_o;

  int checks = 0;
  int errors = 0;

  stage_mem dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (valid_i),
    .is_ld_mem_i     (is_ld_mem_i),
    .is_st_mem_i     (is_st_mem_i),
    .funct3_i        (funct3_i),
    .alu_d_i         (alu_d_i),
    .st_data_i       (st_data_i),
    .flush_i         (flush_i),
    .dwbm_addr_o     (dwbm_addr_o),
    .dwbm_dat_o      (dwbm_dat_o),
    .dwbm_sel_o      (dwbm_sel_o),
    .dwbm_we_o       (dwbm_we_o),
    .dwbm_cyc_o      (dwbm_cyc_o),
    .dwbm_stb_o      (dwbm_stb_o),
    .dwbm_dat_i      (dwbm_dat_i),
    .dwbm_ack_i      (dwbm_ack_i),
    .dwbm_err_i      (dwbm_err_i),
    .mem_d_o         (mem_d_o),
    .stall_o         (stall_o),
    .e_ld_addr_mis_o (e_ld_addr_mis_o),
    .e_st_addr_mis_o (e_st_addr_mis_o),
    .e_bus_err_o     (e_bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic        flush;
    logic        mis_ld;
    logic        mis_st;
    logic        issue;
    logic [31:0] mem;
    logic [3:0]  sel;
    logic [31:0] dat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t hv(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int waits, input logic err,
                              input logic flush, input logic mis_ld, input logic mis_st,
                              input logic issue, input logic [31:0] mem, input logic [3:0] sel,
                              input logic [31:0] dat);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
    v.waits = waits; v.err = err; v.flush = flush; v.mis_ld = mis_ld; v.mis_st = mis_st;
    v.issue = issue; v.mem = mem; v.sel = sel; v.dat = dat;
    return v;
  endfunction

  // Reference model: access size in bytes, legality list, modular arithmetic for lanes.
  function automatic vec_t model(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] rs2, input logic [31:0] rdata,
                                 input int waits, input logic err, input logic flush);
    vec_t   v;
    int     n;
    int     o;
    bit     legal;
    bit     mis;
    longint val;
    longint m;
    v = hv(ld, !ld, f3, addr, rs2, rdata, waits, err, flush, 0, 0, 0, 0, 4'hF, 0);
    n = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    o = int'(addr % 4);
    if (ld) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else    legal = (f3 == 0 || f3 == 1 || f3 == 2);
    mis = legal && (o % n != 0);
    v.mis_ld = ld && mis;
    v.mis_st = !ld && mis;
    v.issue  = legal && !mis && !flush;
    if (!ld) begin
      v.sel = 4'(((1 << n) - 1) << o);
      m = (64'd1 << (8 * n)) - 1;
      v.dat = (n == 1) ? 32'(longint'(rs2) % 256 * 32'h0101_0101) :
              (n == 2) ? 32'(longint'(rs2) % 65536 * 32'h0001_0001) : rs2;
    end else if (!err) begin
      m   = 64'd1 << (8 * n);
      val = (longint'(rdata) >> (8 * o)) % m;
      if (f3 < 4 && val >= m / 2) val = val - m;
      v.mem = 32'(val);
    end
    return v;
  endfunction

  task automatic run(input vec_t v);
    valid_i = 1'b1; is_ld_mem_i = v.ld; is_st_mem_i = v.st; funct3_i = v.f3;
    alu_d_i = v.addr; st_data_i = v.rs2; flush_i = v.flush; dwbm_dat_i = v.rdata;
    dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0;
    @(negedge clk_i);
    chk("mis_ld", {31'h0, e_ld_addr_mis_o}, {31'h0, v.mis_ld});
    chk("mis_st", {31'h0, e_st_addr_mis_o}, {31'h0, v.mis_st});
    chk("stall_issue", {31'h0, stall_o}, {31'h0, v.issue});
    chk("cyc_idle", {31'h0, dwbm_cyc_o}, 32'h0);
    chk("mem_d_idle", mem_d_o, 32'h0);
    @(posedge clk_i); #1;
    if (v.issue) begin
      for (int w = 0; w <= v.waits; w++) begin
        if (w == v.waits) begin
          dwbm_ack_i = 1'b1;
          dwbm_err_i = v.err;
        end
        @(negedge clk_i);
        chk("cyc_bus", {31'h0, dwbm_cyc_o}, 32'h1);
        chk("stb_bus", {31'h0, dwbm_stb_o}, 32'h1);
        chk("we_bus", {31'h0, dwbm_we_o}, {31'h0, v.st});
        chk("addr_bus", dwbm_addr_o, v.addr & 32'hFFFF_FFFC);
        chk("sel_bus", {28'h0, dwbm_sel_o}, {28'h0, v.sel});
        if (v.st) chk("dat_bus", dwbm_dat_o, v.dat);
        chk("stall_bus", {31'h0, stall_o}, {31'h0, w != v.waits});
        chk("mem_d", mem_d_o, (w == v.waits) ? v.mem : 32'h0);
        chk("bus_err", {31'h0, e_bus_err_o}, {31'h0, (w == v.waits) && v.err});
        @(posedge clk_i); #1;
      end
      dwbm_ack_i = 1'b0;
      dwbm_err_i = 1'b0;
    end
    valid_i = 1'b0; is_ld_mem_i = 1'b0; is_st_mem_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("cyc_after", {31'h0, dwbm_cyc_o}, 32'h0);
    chk("stall_after", {31'h0, stall_o}, 32'h0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    rst_i = 1'b1; valid_i = 1'b0; is_ld_mem_i = 1'b0; is_st_mem_i = 1'b0; funct3_i = 3'b000;
    alu_d_i = 32'h0; st_data_i = 32'h0; flush_i = 1'b0; dwbm_dat_i = 32'h0;
    dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_cyc", {31'h0, dwbm_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, dwbm_stb_o}, 32'h0);
    chk("rst_we", {31'h0, dwbm_we_o}, 32'h0);
    chk("rst_addr", dwbm_addr_o, 32'h0);
    chk("rst_dat", dwbm_dat_o, 32'h0);
    chk("rst_sel", {28'h0, dwbm_sel_o}, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_mem_d", mem_d_o, 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    //           ld st f3    addr           rs2            rdata          w  er fl ml ms is mem            sel    dat
    tbl.push_back(hv(1, 0, 3'd0, 32'h0000_1003, 32'h0,         32'h80FF_FF7F, 0, 0, 0, 0, 0, 1, 32'hFFFF_FF80, 4'hF, 0));
    tbl.push_back(hv(0, 1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,         3, 0, 0, 0, 0, 1, 32'h0,         4'hC, 32'hABCD_ABCD));
    tbl.push_back(hv(1, 0, 3'd2, 32'h0000_3001, 32'h0,         32'h0,         0, 0, 0, 1, 0, 0, 32'h0,         4'hF, 0));
    tbl.push_back(hv(0, 1, 3'd2, 32'h0000_3002, 32'h0,         32'h0,         0, 0, 0, 0, 1, 0, 32'h0,         4'hF, 0));
    tbl.push_back(hv(1, 0, 3'd5, 32'h0000_4002, 32'h0,         32'hBEEF_0000, 0, 0, 1, 0, 0, 0, 32'h0,         4'hF, 0));
    tbl.push_back(hv(1, 0, 3'd5, 32'h0000_4002, 32'h0,         32'hBEEF_0000, 0, 0, 0, 0, 0, 1, 32'h0000_BEEF, 4'hF, 0));
    tbl.push_back(hv(1, 0, 3'd2, 32'h0000_5000, 32'h0,         32'hDEAD_BEEF, 0, 1, 0, 0, 0, 1, 32'h0,         4'hF, 0));
    tbl.push_back(hv(0, 1, 3'd0, 32'h0000_6001, 32'h0000_00A5, 32'h0,         1, 0, 0, 0, 0, 1, 32'h0,         4'h2, 32'hA5A5_A5A5));
    tbl.push_back(hv(1, 0, 3'd1, 32'h0000_7002, 32'h0,         32'h8001_0000, 2, 0, 0, 0, 0, 1, 32'hFFFF_8001, 4'hF, 0));
    tbl.push_back(hv(1, 0, 3'd3, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         4'hF, 0));
    tbl.push_back(hv(0, 1, 3'd4, 32'h0000_0001, 32'h0,         32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         4'hF, 0));
    tbl.push_back(hv(1, 0, 3'd1, 32'h0000_7001, 32'h0,         32'h0,         0, 0, 0, 1, 0, 0, 32'h0,         4'hF, 0));
    tbl.push_back(hv(1, 0, 3'd2, 32'h0000_3003, 32'h0,         32'h0,         0, 0, 1, 1, 0, 0, 32'h0,         4'hF, 0));
    tbl.push_back(hv(1, 0, 3'd4, 32'h0000_8002, 32'h0,         32'h0090_0000, 0, 0, 0, 0, 0, 1, 32'h0000_0090, 4'hF, 0));
    foreach (tbl[i]) run(tbl[i]);

    for (int i = 0; i < 60; i++) begin
      v = model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom, int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0);
      run(v);
    end

    // Reset while waiting in BUS: bus outputs must drop before the next edge; a late ack is inert.
    run_reset_case();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic run_reset_case();
    valid_i = 1'b1; is_ld_mem_i = 1'b0; is_st_mem_i = 1'b1; funct3_i = 3'd2;
    alu_d_i = 32'h0000_9000; st_data_i = 32'h5555_AAAA; flush_i = 1'b0;
    dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst_case_cyc_before", {31'h0, dwbm_cyc_o}, 32'h1);
    chk("rst_case_we_before", {31'h0, dwbm_we_o}, 32'h1);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    valid_i = 1'b0; is_st_mem_i = 1'b0;
    #1;
    chk("rst_case_cyc", {31'h0, dwbm_cyc_o}, 32'h0);
    chk("rst_case_stb", {31'h0, dwbm_stb_o}, 32'h0);
    chk("rst_case_we", {31'h0, dwbm_we_o}, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    dwbm_ack_i = 1'b1; dwbm_err_i = 1'b1; dwbm_dat_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    chk("late_ack_mem_d", mem_d_o, 32'h0);
    chk("late_ack_bus_err", {31'h0, e_bus_err_o}, 32'h0);
    chk("late_ack_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk_i); #1;
    dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0;
    @(negedge clk_i);
    chk("late_ack_cyc", {31'h0, dwbm_cyc_o}, 32'h0);
  endtask

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access pipeline stage, directly upstream of `stage_wb`. It converts load/store micro-ops from execute into single data-bus cycles and checks alignment. It formats load data into the `mem_d` value consumed by write-back, and stalls the pipeline until the bus acknowledges. Misaligned accesses are reported as exceptions without touching the bus.

## Interface
- No parameters.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `valid_i` in 1: a valid instruction occupies this stage.
- `is_ld_mem_i` in 1: the instruction is a load.
- `is_st_mem_i` in 1: the instruction is a store.
- `funct3_i` in 3: access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `alu_d_i` in 32: effective byte address.
- `st_data_i` in 32: store source (rs2).
- `flush_i` in 1: downstream exception taken this cycle (`is_exc_taken` from WB); suppresses a new access.
- `dwbm_addr_o` out 32: word-aligned bus address.
- `dwbm_dat_o` out 32: store data, lane-replicated.
- `dwbm_sel_o` out 4: byte-lane enables.
- `dwbm_we_o` out 1: write cycle.
- `dwbm_cyc_o` out 1: bus cycle active.
- `dwbm_stb_o` out 1: bus strobe.
- `dwbm_dat_i` in 32: read data.
- `dwbm_ack_i` in 1: cycle done.
- `dwbm_err_i` in 1: bus error, terminates the cycle.
- `mem_d_o` out 32: formatted load data, valid in the completion cycle.
- `stall_o` out 1: hold all upstream stages and this stage's inputs.
- `e_ld_addr_mis_o` out 1: misaligned load.
- `e_st_addr_mis_o` out 1: misaligned store.
- `e_bus_err_o` out 1: bus error on the current access.

## Operation
- `req = valid_i & (is_ld_mem_i | is_st_mem_i)`.
- Misalignment rules:
  - H/HU is misaligned when `addr[0]` = 1.
  - W is misaligned when `addr[1:0]` ≠ 0.
  - B/BU is never misaligned.
- Misalignment flags are combinational, qualified by `req`. The access is not issued and no stall occurs.
- `funct3` values 011, 110, 111 (and 100/101 on stores) are no-ops: no bus cycle, no flag. Illegal-instruction reporting happens upstream.
- `start = req & aligned & legal & !flush_i & state==IDLE`.
- FSM has two states, IDLE and BUS.
  - IDLE → BUS on `start`. At that edge the stage registers:
    - `dwbm_addr_o = {addr[31:2], 2'b00}`
    - `we = is_st_mem_i`
    - `sel`, `dat`
    - byte offset `addr[1:0]` and `funct3` for load formatting
    - `cyc = stb = 1`
  - BUS → IDLE on `ack_i | err_i`. At that edge `cyc`, `stb` and `we` are cleared.
  - If `ack_i` and `err_i` are both high, `err_i` wins.
- Store lanes:
  - SB: `sel = 4'b0001 << off`, `dat = {4{rs2[7:0]}}`.
  - SH: `sel = off[1] ? 4'b1100 : 4'b0011`, `dat = {2{rs2[15:0]}}`.
  - SW: `sel = 4'b1111`, `dat = rs2`.
- Loads always use `sel = 4'b1111`.
- Load formatting:
  - Combinational from `dwbm_dat_i` and the registered offset/`funct3`.
  - Lane = `dat_i >> (8*off)`.
  - B/H are sign-extended; BU/HU are zero-extended.
  - `mem_d_o = 0` when not completing a load.
- `stall_o = (state==IDLE & start) | (state==BUS & !(ack_i | err_i))`.
- `e_bus_err_o = state==BUS & err_i`. In that cycle `mem_d_o` is 0.
- `flush_i` is examined only in IDLE. A cycle in BUS always runs to ack/err and is never aborted.

## Timing
- Reset values:
  - State IDLE.
  - `cyc`, `stb`, `we` = 0.
  - `addr`, `dat`, `sel` = 0.
  - Registered offset/`funct3` = 0.
- `stall_o`, `mem_d_o` and the `e_*` flags are combinational and are 0 whenever `valid_i` = 0 in IDLE.
- Reset asserted mid-access drops `cyc`/`stb` immediately (asynchronous) and abandons the bus cycle. Any late ack after reset is ignored in IDLE.
- Minimum access is 2 cycles:
  - Cycle 0 (IDLE): `start`, `stall_o` = 1.
  - Cycle 1 (BUS): `cyc`/`stb` high. With zero-wait `ack_i`, `stall_o` = 0 and `mem_d_o` is valid, and the pipeline advances at the end of cycle 1.
- Each wait state adds one cycle with `stall_o` = 1.
- Back-to-back accesses: a new `start` occurs in the cycle after completion. `cyc` is low for at least one cycle between accesses.
- A misaligned access completes in 0 extra cycles (flag in cycle 0, no stall).
- `flush_i` and `req` in the same IDLE cycle: no access, no stall, no flags suppressed. WB ignores the flags because it is flushing.
- Outputs of `dwbm_*` are held stable for the whole BUS state.

## Test plan
- LB at 0x1003, slave returns 0x80FF_FF7F with 0-wait ack → `addr_o` 0x1000, `sel` 1111, `mem_d_o` 0xFFFF_FF80, `stall_o` high exactly 1 cycle.
- SH at 0x2002, rs2 = 0x1234_ABCD, ack after 3 wait cycles → `dat_o` 0xABCD_ABCD, `sel` 1100, `we` 1, `stall_o` high 4 cycles, `cyc` drops with ack.
- LW at 0x3001 → `e_ld_addr_mis_o` = 1 same cycle, `cyc` never rises, `stall_o` = 0. SW at 0x3002 → `e_st_addr_mis_o` = 1.
- LHU at 0x4002 with `flush_i` = 1 → no bus cycle. Next cycle LHU with `flush_i` = 0, data 0xBEEF_0000 → `mem_d_o` 0x0000_BEEF.
- LW at 0x5000, slave asserts `ack_i` and `err_i` together → `e_bus_err_o` = 1, `mem_d_o` = 0, FSM to IDLE.
- Assert `rst_i` during BUS wait → `cyc`/`stb`/`we` low before the next clock edge. A later `ack_i` produces no `mem_d_o` and no flag.
